// File: rtl/stream_arb2.sv
// Two-input round-robin valid/ready arbiter with burst locking and a one-entry
// registered output slot; sel/ready are combinational, data path is registered.
module stream_arb2 #(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BEAT_LAST = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_src_q, out_src_d;

    logic             free_s;
    logic             owner_s;
    logic             owner_valid_s;
    logic             xfer_s;
    logic [WIDTH-1:0] xfer_data_s;

    // State and output-slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            beat_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            beat_cnt_q  <= beat_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
        end
    end

    // Owner selection, handshake and mux select (no path from input data)
    always_comb begin
        free_s = !out_valid_q || out_ready;
        case (state_q)
            GRANT0: owner_s = 1'b0;
            GRANT1: owner_s = 1'b1;
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    owner_s = !last_q;
                end else if (in0_valid) begin
                    owner_s = 1'b0;
                end else if (in1_valid) begin
                    owner_s = 1'b1;
                end else begin
                    owner_s = !last_q;
                end
            end
            default: owner_s = 1'b0;
        endcase
        sel           = owner_s;
        in0_ready     = free_s && !owner_s;
        in1_ready     = free_s && owner_s;
        owner_valid_s = owner_s ? in1_valid : in0_valid;
        xfer_s        = owner_valid_s && free_s;
        xfer_data_s   = owner_s ? in1_data : in0_data;
    end

    // Next-state: burst tracking, early release and round-robin pointer
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    if (BURST_LEN > 1) begin
                        state_d    = owner_s ? GRANT1 : GRANT0;
                        beat_cnt_d = CW'(1);
                    end else begin
                        last_d = owner_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT0, GRANT1: begin
                if (!owner_valid_s) begin
                    // Owner went quiet: hand back to arbitration even if stalled
                    state_d    = IDLE;
                    last_d     = owner_s;
                    beat_cnt_d = '0;
                end else if (xfer_s) begin
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d    = IDLE;
                        last_d     = owner_s;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = IDLE;
                last_d     = 1'b1;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Output slot: load on transfer, drain when free, hold on stall
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        if (xfer_s) begin
            out_data_d  = xfer_data_s;
            out_valid_d = 1'b1;
            out_src_d   = owner_s;
        end else if (free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Directed bench for stream_arb2: a per-cycle vector table for BURST_LEN=4
// plus hand sequences for continuous fairness, BURST_LEN=1 and async reset.
module tb_stream_arb2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in0_data = 16'h0000, in1_data = 16'h0000;
    logic        in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b1;

    logic        in0_ready, in1_ready, sel, out_valid, out_src;
    logic [15:0] out_data;
    logic        b1_in0_ready, b1_in1_ready, b1_sel, b1_out_valid, b1_out_src;
    logic [15:0] b1_out_data;

    int n_chk = 0;
    int n_fail = 0;
    int c0, c1;

    always #5 clk = ~clk;

    stream_arb2 #(.WIDTH(16), .BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src)
    );

    stream_arb2 #(.WIDTH(16), .BURST_LEN(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(b1_in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(b1_in1_ready),
        .sel(b1_sel), .out_data(b1_out_data), .out_valid(b1_out_valid),
        .out_ready(out_ready), .out_src(b1_out_src)
    );

    typedef struct {
        logic        v0, v1, ordy;
        logic [15:0] d0, d1;
        logic        sel, r0, r1, ov;
        logic [15:0] od;
        logic        os;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v0, input logic v1, input logic ordy,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic s, input logic r0, input logic r1,
                                input logic ov, input logic [15:0] od, input logic os);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.ordy = ordy; v.d0 = d0; v.d1 = d1;
        v.sel = s; v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.os = os;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected j-th output word under continuous contention with BURST_LEN=4
    function automatic logic [15:0] exp_word(input int j);
        logic s;
        int   idx;
        s   = ((j / 4) % 2) != 0;
        idx = (j / 8) * 4 + (j % 4);
        return {3'b000, s, 12'(idx)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //   v0    v1    rdy   d0        d1        sel   r0    r1    ov    od        os
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        add(1'b0, 1'b1, 1'b1, 16'h0000, 16'h1001, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h0001, 16'h1002, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1001, 1'b1);
        add(1'b1, 1'b1, 1'b1, 16'h0001, 16'h1003, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1002, 1'b1);
        add(1'b1, 1'b1, 1'b1, 16'h0001, 16'h1004, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1003, 1'b1);
        add(1'b1, 1'b1, 1'b1, 16'h0001, 16'h1005, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1004, 1'b1);
        add(1'b1, 1'b1, 1'b1, 16'h0002, 16'h1005, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0);
        add(1'b1, 1'b1, 1'b0, 16'h0003, 16'h1005, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
        add(1'b1, 1'b1, 1'b0, 16'h0003, 16'h1005, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
        add(1'b1, 1'b1, 1'b0, 16'h0003, 16'h1005, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h0003, 16'h1005, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h0004, 16'h1005, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h0005, 16'h1005, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h0005, 16'h1006, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1005, 1'b1);
        add(1'b1, 1'b0, 1'b1, 16'h0005, 16'h1007, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1006, 1'b1);
        add(1'b1, 1'b1, 1'b1, 16'h0005, 16'h1007, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h0006, 16'h1007, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0);
        add(1'b0, 1'b1, 1'b1, 16'h0006, 16'h1007, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0006, 1'b0);
        add(1'b0, 1'b1, 1'b1, 16'h0006, 16'h1007, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0006, 16'h1007, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1007, 1'b1);
        add(1'b1, 1'b1, 1'b1, 16'h0007, 16'h1007, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0007, 16'h1007, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0007, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0007, 16'h1007, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table: registered outputs reflect the previous edge, handshakes this cycle
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            in0_valid = tbl[i].v0; in1_valid = tbl[i].v1; out_ready = tbl[i].ordy;
            in0_data  = tbl[i].d0; in1_data  = tbl[i].d1;
            #1;
            chk($sformatf("v%0d.sel", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("v%0d.in0_ready", i), 32'(in0_ready), 32'(tbl[i].r0));
            chk($sformatf("v%0d.in1_ready", i), 32'(in1_ready), 32'(tbl[i].r1));
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov || i == 0) begin
                chk($sformatf("v%0d.out_data", i), 32'(out_data), 32'(tbl[i].od));
                chk($sformatf("v%0d.out_src", i), 32'(out_src), 32'(tbl[i].os));
            end
        end

        // Continuous contention: 4x in0, 4x in1, 4x in0 with no gaps; BURST_LEN=1 alternates
        do_reset();
        c0 = 0; c1 = 0;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("fair%0d.out_valid", i - 1), 32'(out_valid), 32'd1);
                chk($sformatf("fair%0d.out_data", i - 1), 32'(out_data), 32'(exp_word(i - 1)));
                chk($sformatf("fair%0d.out_src", i - 1), 32'(out_src), 32'(exp_word(i - 1) >> 12));
                chk($sformatf("b1_%0d.out_valid", i - 1), 32'(b1_out_valid), 32'd1);
                chk($sformatf("b1_%0d.out_src", i - 1), 32'(b1_out_src), 32'((i - 1) % 2));
            end
            in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
            in0_data = {4'h0, 12'(c0)};
            in1_data = {4'h1, 12'(c1)};
            #1;
            if (in0_ready) c0++;
            if (in1_ready) c1++;
        end

        // Async reset in GRANT1 with beat_cnt = 2
        do_reset();
        @(negedge clk);
        in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 16'h1AAA;
        @(negedge clk);
        in1_data = 16'h1AAB;
        @(negedge clk);
        chk("prerst.out_valid", 32'(out_valid), 32'd1);
        chk("prerst.out_data", 32'(out_data), 32'h1AAB);
        chk("prerst.sel", 32'(sel), 32'd1);
        #2;
        in1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'h0000);
        chk("rst.out_src", 32'(out_src), 32'd0);
        chk("rst.sel", 32'(sel), 32'd0);
        chk("rst.in0_ready", 32'(in0_ready), 32'd1);
        chk("rst.in1_ready", 32'(in1_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_data = 16'h0ABC; in1_data = 16'h1ABC;
        #1;
        chk("posttie.sel", 32'(sel), 32'd0);
        chk("posttie.in0_ready", 32'(in0_ready), 32'd1);
        chk("posttie.in1_ready", 32'(in1_ready), 32'd0);
        @(negedge clk);
        chk("posttie.out_valid", 32'(out_valid), 32'd1);
        chk("posttie.out_src", 32'(out_src), 32'd0);
        chk("posttie.out_data", 32'(out_data), 32'h0ABC);
        in0_valid = 1'b0; in1_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
